asi_usr_arb: RTL and testbench



---
 rtl/asi_usr_arb.sv | 164 ++++++++++++++++
 tb/tb_asi_usr_arb.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/asi_usr_arb.sv
// Burst-granular arbiter for the shared user-side memory port: grants read or
// write engine for a full burst, counts its beats, and adds read-to-write turnaround.
module asi_usr_arb #(
   parameter int AXI_LW   = 8,
   parameter int ASI_ARB  = 0,
   parameter int ARB_MAXC = 4,
   parameter int ARB_TA   = 1
) (
   input  logic              usr_clk,
   input  logic              usr_reset,
   input  logic              rd_req,
   input  logic [AXI_LW-1:0] rd_len,
   input  logic              rd_beat,
   output logic              rd_gnt,
   output logic              rd_last,
   input  logic              wr_req,
   input  logic [AXI_LW-1:0] wr_len,
   input  logic              wr_beat,
   output logic              wr_gnt,
   output logic              wr_last,
   output logic              arb_busy,
   output logic              proto_err
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RD   = 2'd1;
   localparam logic [1:0] ST_WR   = 2'd2;
   localparam logic [1:0] ST_TURN = 2'd3;

   localparam logic [1:0] SIDE_NONE = 2'd0;
   localparam logic [1:0] SIDE_RD   = 2'd1;
   localparam logic [1:0] SIDE_WR   = 2'd2;

   localparam logic [3:0]        MAXC   = 4'(ARB_MAXC);
   localparam logic [2:0]        TA     = 3'(ARB_TA);
   localparam logic              PRI_RD = (ASI_ARB != 0);
   localparam logic [AXI_LW-1:0] CNT_ONE = {{(AXI_LW-1){1'b0}}, 1'b1};

   logic [1:0]        st_r;
   logic [AXI_LW-1:0] cnt_r;
   logic [AXI_LW-1:0] len_r;
   logic [3:0]        cons_r;
   logic [1:0]        side_r;
   logic [2:0]        ta_r;
   logic              err_r;

   logic              decide_s;
   logic              win_rd_s;
   logic              win_wr_s;
   logic [3:0]        rd_cons_s;
   logic [3:0]        wr_cons_s;
   logic [3:0]        rd_cons_nxt_s;
   logic [3:0]        wr_cons_nxt_s;
   logic              err_s;

   assign rd_gnt    = (st_r == ST_RD);
   assign wr_gnt    = (st_r == ST_WR);
   assign arb_busy  = (st_r != ST_IDLE);
   assign proto_err = err_r;
   assign rd_last   = rd_gnt & rd_beat & (cnt_r == len_r);
   assign wr_last   = wr_gnt & wr_beat & (cnt_r == len_r);

   // Decision point, per-side consecutive counts and protocol violation detect
   always_comb begin
      decide_s  = (st_r == ST_IDLE) | rd_last | wr_last;
      rd_cons_s = (side_r == SIDE_RD) ? cons_r : 4'd0;
      wr_cons_s = (side_r == SIDE_WR) ? cons_r : 4'd0;
      if (side_r == SIDE_RD) begin
         rd_cons_nxt_s = (cons_r == MAXC) ? MAXC : cons_r + 4'd1;
      end else begin
         rd_cons_nxt_s = 4'd1;
      end
      if (side_r == SIDE_WR) begin
         wr_cons_nxt_s = (cons_r == MAXC) ? MAXC : cons_r + 4'd1;
      end else begin
         wr_cons_nxt_s = 4'd1;
      end
      err_s = (rd_beat & ~rd_gnt) | (wr_beat & ~wr_gnt) | (rd_beat & wr_beat);
   end

   // Winner selection: fixed priority, overridden once the favoured side hits its cap
   always_comb begin
      win_rd_s = 1'b0;
      win_wr_s = 1'b0;
      if (rd_req && wr_req) begin
         if (PRI_RD) begin
            if (rd_cons_s == MAXC) begin
               win_wr_s = 1'b1;
            end else begin
               win_rd_s = 1'b1;
            end
         end else begin
            if (wr_cons_s == MAXC) begin
               win_rd_s = 1'b1;
            end else begin
               win_wr_s = 1'b1;
            end
         end
      end else if (rd_req) begin
         win_rd_s = 1'b1;
      end else if (wr_req) begin
         win_wr_s = 1'b1;
      end else begin
         win_rd_s = 1'b0;
         win_wr_s = 1'b0;
      end
   end

   // State, burst bookkeeping and sticky error register
   always_ff @(posedge usr_clk) begin
      if (usr_reset) begin
         st_r   <= ST_IDLE;
         cnt_r  <= '0;
         len_r  <= '0;
         cons_r <= 4'd0;
         side_r <= SIDE_NONE;
         ta_r   <= 3'd0;
         err_r  <= 1'b0;
      end else begin
         err_r <= err_r | err_s;
         case (st_r)
            ST_IDLE, ST_RD, ST_WR: begin
               if (decide_s) begin
                  cnt_r <= '0;
                  if (win_rd_s) begin
                     st_r   <= ST_RD;
                     len_r  <= rd_len;
                     cons_r <= rd_cons_nxt_s;
                     side_r <= SIDE_RD;
                  end else if (win_wr_s) begin
                     cons_r <= wr_cons_nxt_s;
                     side_r <= SIDE_WR;
                     // write grant is committed here; its length is taken when WR is entered
                     if ((st_r == ST_RD) && (TA != 3'd0)) begin
                        st_r <= ST_TURN;
                        ta_r <= TA - 3'd1;
                     end else begin
                        st_r  <= ST_WR;
                        len_r <= wr_len;
                     end
                  end else begin
                     st_r <= ST_IDLE;
                  end
               end else if ((rd_gnt && rd_beat) || (wr_gnt && wr_beat)) begin
                  cnt_r <= cnt_r + CNT_ONE;
               end
            end
            ST_TURN: begin
               if (ta_r == 3'd0) begin
                  st_r  <= ST_WR;
                  len_r <= wr_len;
                  cnt_r <= '0;
               end else begin
                  ta_r <= ta_r - 3'd1;
               end
            end
            default: begin
               st_r <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_asi_usr_arb.sv
// Directed testbench for asi_usr_arb: main instance with a 2-cycle turnaround,
// plus a zero-turnaround instance driven by the same stimulus.
module tb_asi_usr_arb;

   logic       usr_clk;
   logic       usr_reset;
   logic       rd_req;
   logic [7:0] rd_len;
   logic       rd_beat;
   logic       wr_req;
   logic [7:0] wr_len;
   logic       wr_beat;

   logic rd_gnt, rd_last, wr_gnt, wr_last, arb_busy, proto_err;
   logic rd_gnt0, rd_last0, wr_gnt0, wr_last0, arb_busy0, proto_err0;

   int checks = 0;
   int errors = 0;

   asi_usr_arb #(.AXI_LW(8), .ASI_ARB(0), .ARB_MAXC(4), .ARB_TA(2)) dut (
      .usr_clk(usr_clk), .usr_reset(usr_reset),
      .rd_req(rd_req), .rd_len(rd_len), .rd_beat(rd_beat),
      .rd_gnt(rd_gnt), .rd_last(rd_last),
      .wr_req(wr_req), .wr_len(wr_len), .wr_beat(wr_beat),
      .wr_gnt(wr_gnt), .wr_last(wr_last),
      .arb_busy(arb_busy), .proto_err(proto_err)
   );

   asi_usr_arb #(.AXI_LW(8), .ASI_ARB(0), .ARB_MAXC(4), .ARB_TA(0)) dut0 (
      .usr_clk(usr_clk), .usr_reset(usr_reset),
      .rd_req(rd_req), .rd_len(rd_len), .rd_beat(rd_beat),
      .rd_gnt(rd_gnt0), .rd_last(rd_last0),
      .wr_req(wr_req), .wr_len(wr_len), .wr_beat(wr_beat),
      .wr_gnt(wr_gnt0), .wr_last(wr_last0),
      .arb_busy(arb_busy0), .proto_err(proto_err0)
   );

   initial usr_clk = 1'b0;
   always #5 usr_clk = ~usr_clk;

   task automatic tick();
      @(posedge usr_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic got, input logic exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%b expected=%b", tag, got, exp);
      end
   endtask

   // Caller is one step after the edge that granted the burst; ends one step after the edge following the last beat.
   task automatic burst(input logic is_rd, input int beats, input string tag);
      chk({tag, "_gnt"}, is_rd ? rd_gnt : wr_gnt, 1'b1);
      chk({tag, "_other_gnt"}, is_rd ? wr_gnt : rd_gnt, 1'b0);
      rd_beat = is_rd;
      wr_beat = ~is_rd;
      for (int i = 0; i < beats; i++) begin
         #1;
         chk({tag, "_last"}, is_rd ? rd_last : wr_last, (i == beats - 1) ? 1'b1 : 1'b0);
         tick();
      end
      rd_beat = 1'b0;
      wr_beat = 1'b0;
   endtask

   initial begin
      usr_reset = 1'b1;
      rd_req = 1'b0; rd_len = 8'd0; rd_beat = 1'b0;
      wr_req = 1'b0; wr_len = 8'd0; wr_beat = 1'b0;
      tick();
      tick();
      chk("reset_rd_gnt", rd_gnt, 1'b0);
      chk("reset_wr_gnt", wr_gnt, 1'b0);
      chk("reset_busy", arb_busy, 1'b0);
      chk("reset_err", proto_err, 1'b0);
      usr_reset = 1'b0;

      // single read burst of 4 beats
      rd_req = 1'b1; rd_len = 8'd3;
      chk("t1_no_gnt_yet", rd_gnt, 1'b0);
      tick();
      rd_req = 1'b0;
      burst(1'b1, 4, "t1_rd");
      chk("t1_idle_busy", arb_busy, 1'b0);
      chk("t1_idle_gnt", rd_gnt, 1'b0);

      // simultaneous single-beat requests: write first, read with no bubble
      rd_req = 1'b1; rd_len = 8'd0;
      wr_req = 1'b1; wr_len = 8'd0;
      tick();
      wr_req = 1'b0;
      burst(1'b0, 1, "t2_wr");
      rd_req = 1'b0;
      burst(1'b1, 1, "t2_rd");
      chk("t2_idle_busy", arb_busy, 1'b0);

      // fairness cap: 4 writes, 1 read, then writes again
      rd_req = 1'b1; rd_len = 8'd1;
      wr_req = 1'b1; wr_len = 8'd1;
      tick();
      for (int k = 0; k < 4; k++) burst(1'b0, 2, "t3_wr");
      burst(1'b1, 2, "t3_rd");
      chk("t3_turn1_rd", rd_gnt, 1'b0);
      chk("t3_turn1_wr", wr_gnt, 1'b0);
      chk("t3_turn1_busy", arb_busy, 1'b1);
      tick();
      chk("t3_turn2_wr", wr_gnt, 1'b0);
      tick();
      rd_req = 1'b0;
      wr_req = 1'b0;
      burst(1'b0, 2, "t3_wr_after");
      chk("t3_idle_busy", arb_busy, 1'b0);

      // read-to-write turnaround: 2 idle cycles on main, none on dut0
      rd_req = 1'b1; rd_len = 8'd2;
      tick();
      rd_req = 1'b0;
      wr_req = 1'b1; wr_len = 8'd0;
      burst(1'b1, 3, "t4_rd");
      chk("t4_ta0_wr_gnt", wr_gnt0, 1'b1);
      chk("t4_turn1_wr", wr_gnt, 1'b0);
      chk("t4_turn1_rd", rd_gnt, 1'b0);
      tick();
      chk("t4_turn2_wr", wr_gnt, 1'b0);
      chk("t4_turn2_rd", rd_gnt, 1'b0);
      tick();
      wr_req = 1'b0;
      burst(1'b0, 1, "t4_wr");
      chk("t4_idle_busy", arb_busy, 1'b0);
      chk("t4_ta0_idle_busy", arb_busy0, 1'b0);
      chk("t4_no_err", proto_err, 1'b0);

      // protocol errors: foreign beat during RD, beat in IDLE
      rd_req = 1'b1; rd_len = 8'd3;
      tick();
      rd_req = 1'b0;
      rd_beat = 1'b1;
      #1 chk("t5_last0", rd_last, 1'b0);
      tick();
      wr_beat = 1'b1;
      #1 chk("t5_last1", rd_last, 1'b0);
      tick();
      wr_beat = 1'b0;
      chk("t5_err_set", proto_err, 1'b1);
      #1 chk("t5_last2", rd_last, 1'b0);
      tick();
      #1 chk("t5_last3", rd_last, 1'b1);
      tick();
      rd_beat = 1'b0;
      chk("t5_idle_busy", arb_busy, 1'b0);
      wr_beat = 1'b1;
      tick();
      wr_beat = 1'b0;
      chk("t5_err_sticky", proto_err, 1'b1);
      chk("t5_idle_no_gnt", wr_gnt, 1'b0);
      usr_reset = 1'b1;
      tick();
      usr_reset = 1'b0;
      chk("t5_err_cleared", proto_err, 1'b0);

      // reset in the middle of a 256-beat write burst
      wr_req = 1'b1; wr_len = 8'd255;
      tick();
      wr_req = 1'b0;
      chk("t6_wr_gnt", wr_gnt, 1'b1);
      wr_beat = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      #1 chk("t6_cnt5_last", wr_last, 1'b0);
      usr_reset = 1'b1;
      wr_beat = 1'b0;
      tick();
      usr_reset = 1'b0;
      chk("t6_rst_gnt", wr_gnt, 1'b0);
      chk("t6_rst_busy", arb_busy, 1'b0);
      wr_req = 1'b1;
      tick();
      wr_req = 1'b0;
      burst(1'b0, 256, "t6_full");
      chk("t6_idle_busy", arb_busy, 1'b0);
      chk("t6_no_err", proto_err, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
